dcache_mem_stage: RTL and testbench

//  MEM-stage data cache fed by the EX/MEM register (MemRead, MemWrite, ALU result
//  as address, RS2 data as store data). Direct-mapped, write-back, write-allocate;
//  a hit completes in the same cycle, a miss stalls the pipeline via stall_o while
//  an FSM writes back the dirty victim and refills the line from off-chip memory.

---
 rtl/dcache_mem_stage.sv | 161 ++++++++++++++++
 tb/tb_dcache_mem_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_stage.sv
// Direct-mapped write-back, write-allocate data cache for the MEM stage.
// Misses stall the pipeline while the FSM writes back the victim and refills the line.
//
// state     | meaning
// S_IDLE    | hits complete in-cycle; a miss launches write-back or refill
// S_WRITEBACK | dirty victim line being written to memory
// S_REFILL  | requested line being fetched from memory
// S_REPLAY  | one stall cycle so the access re-executes as a hit
module dcache_mem_stage #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 5 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_REPLAY} state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  logic                 r_mem_req;
  logic                 r_mem_write;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_wdata;

  logic [2:0]           w_off;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_access;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_ack;
  logic                 w_victim_dirty;
  logic                 w_store_hit;
  logic [7:0]           w_bitpos;
  logic [LINE_BITS-1:0] w_line;
  logic [31:0]          w_word;
  logic [ADDR_W-1:0]    w_victim_addr;
  logic [ADDR_W-1:0]    w_line_addr;

  assign w_off          = addr_i[4:2];
  assign w_idx          = addr_i[5 +: IDX_W];
  assign w_tag          = addr_i[ADDR_W-1 -: TAG_W];
  assign w_access       = MemRead_i | MemWrite_i;
  assign w_hit          = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss         = w_access & ~w_hit;
  assign w_ack          = mem_ack_i & r_mem_req;
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
  assign w_store_hit    = (r_state == S_IDLE) & MemWrite_i & w_hit & ~rst_i;
  assign w_bitpos       = {w_off, 5'b00000};
  assign w_line         = r_data[w_idx];
  assign w_word         = w_line[w_bitpos +: 32];
  assign w_victim_addr  = {r_tag[w_idx], w_idx, 5'b00000};
  assign w_line_addr    = {addr_i[ADDR_W-1:5], 5'b00000};

  assign rdata_o     = (~rst_i & MemRead_i & w_hit) ? w_word : 32'h0;
  assign mem_req_o   = r_mem_req;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_miss) w_next = w_victim_dirty ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (w_ack) w_next = S_REFILL;
      S_REFILL:    if (w_ack) w_next = S_REPLAY;
      S_REPLAY:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) stall_o = (r_state == S_IDLE) ? w_miss : 1'b1;
  end

  // Write-back hands straight over to the refill, so req stays high between them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= '0;
      r_dirty     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_mem_req <= 1'b1;
            if (w_victim_dirty) begin
              r_mem_write <= 1'b1;
              r_mem_addr  <= w_victim_addr;
              r_mem_wdata <= w_line;
            end else begin
              r_mem_write <= 1'b0;
              r_mem_addr  <= w_line_addr;
            end
          end else if (w_store_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (w_ack) begin
            r_dirty[w_idx] <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_addr     <= w_line_addr;
          end
        end
        S_REFILL: begin
          if (w_ack) begin
            r_mem_req      <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_tag[w_idx]   <= w_tag;
          end
        end
        default: ;
      endcase
    end
  end

  // Data array is deliberately left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if ((r_state == S_REFILL) && w_ack)
        r_data[w_idx] <= mem_rdata_i;
      else if (w_store_hit)
        r_data[w_idx][w_bitpos +: 32] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Bench for dcache_mem_stage: a flat-memory reference model predicts load data,
// memory transactions and stall length; a monitor and a memory responder check them.
module tb_dcache_mem_stage;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         MemRead_i, MemWrite_i;
  logic [31:0]  addr_i, wdata_i;
  logic [31:0]  rdata_o;
  logic         stall_o, mem_req_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [255:0] mem_rdata_i;

  always #5 clk = ~clk;

  dcache_mem_stage dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {bit is_load; logic [31:0] addr; logic [31:0] data;} exp_t;
  typedef struct {bit wr; logic [31:0] addr; logic [255:0] wdata;} mexp_t;

  exp_t  exp_q[$];
  mexp_t mexp_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] golden  [int unsigned];
  logic [31:0] backing [int unsigned];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [22:0] m_tag   [16];

  int lat_sum = 0;
  int fixed_lat = 0;
  bit hold_ack = 0;
  bit late_ack = 0;

  function automatic logic [31:0] init_val(int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] rd_golden(int unsigned w);
    return golden.exists(w) ? golden[w] : init_val(w);
  endfunction

  function automatic logic [31:0] rd_backing(int unsigned w);
    return backing.exists(w) ? backing[w] : init_val(w);
  endfunction

  function automatic logic [255:0] golden_line(logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rd_golden((la >> 2) + i);
    return l;
  endfunction

  function automatic logic [255:0] backing_line(logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rd_backing((la >> 2) + i);
    return l;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    exp_q.delete();
    mexp_q.delete();
    golden = backing;
  endtask

  // Completed pipeline accesses
  always @(negedge clk) begin
    if (!rst_i && (MemRead_i || MemWrite_i) && !stall_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: addr %h with no pending access", addr_i);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("access_addr", addr_i, e.addr);
        if (e.is_load) check("load_data", rdata_o, e.data);
      end
    end
  end

  // Memory responder
  initial begin
    bit           active;
    bit           cur_wr;
    int           cnt;
    logic [31:0]  cur_addr;
    mexp_t        me;
    active = 0;
    cnt = 0;
    cur_wr = 0;
    cur_addr = '0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (late_ack) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = {8{32'hBAD0_BAD0}};
        late_ack = 0;
      end
      if (rst_i) begin
        active = 0;
      end else begin
        if (mem_req_o && !active) begin
          if (mexp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req: addr %h write %0d", mem_addr_o, mem_write_o);
          end else begin
            me = mexp_q.pop_front();
            check("mem_write", mem_write_o, me.wr);
            check("mem_addr", mem_addr_o, me.addr);
            if (me.wr) check("wb_data", mem_wdata_o, me.wdata);
          end
          active = 1;
          cur_addr = mem_addr_o;
          cur_wr = mem_write_o;
          cnt = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
          lat_sum += cnt;
        end else if (active) begin
          check("mem_req_held", mem_req_o, 1);
          check("mem_addr_stable", mem_addr_o, cur_addr);
        end
        if (active && !hold_ack) begin
          cnt--;
          if (cnt == 0) begin
            mem_ack_i = 1'b1;
            if (cur_wr) begin
              for (int i = 0; i < 8; i++) backing[(cur_addr >> 2) + i] = mem_wdata_o[i*32 +: 32];
            end else begin
              mem_rdata_i = backing_line(cur_addr);
            end
            active = 0;
          end
        end
      end
    end
  end

  task automatic do_access(bit rd, bit wr, logic [31:0] addr, logic [31:0] wd);
    int          idx;
    int          n;
    bit          hit;
    logic [22:0] tg;
    exp_t        e;
    mexp_t       me;
    idx = int'(addr[8:5]);
    tg = addr[31:9];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (rd || wr) begin
      if (!hit) begin
        if (m_valid[idx] && m_dirty[idx]) begin
          me.wr = 1;
          me.addr = {m_tag[idx], addr[8:5], 5'b00000};
          me.wdata = golden_line(me.addr);
          mexp_q.push_back(me);
        end
        me.wr = 0;
        me.addr = {addr[31:5], 5'b00000};
        me.wdata = '0;
        mexp_q.push_back(me);
        m_valid[idx] = 1;
        m_tag[idx] = tg;
        m_dirty[idx] = 0;
      end
      if (wr) begin
        golden[addr >> 2] = wd;
        m_dirty[idx] = 1;
      end
      e.is_load = rd && !wr;
      e.addr = addr;
      e.data = rd_golden(addr >> 2);
      exp_q.push_back(e);
    end
    lat_sum = 0;
    @(posedge clk);
    #1;
    MemRead_i = rd;
    MemWrite_i = wr;
    addr_i = addr;
    wdata_i = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: addr %h still stalled after %0d cycles", addr, n);
        break;
      end
    end
    if (rd || wr) check("stall_cycles", n, hit ? 0 : lat_sum + 2);
    else          check("idle_no_req", mem_req_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic [31:0] a;
    rst_i = 1'b1;
    MemRead_i = 1'b1;
    MemWrite_i = 1'b0;
    addr_i = 32'h40;
    wdata_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_write", mem_write_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_rdata", rdata_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    MemRead_i = 1'b0;
    addr_i = '0;

    // Cold miss with slow memory, then hit on the refilled word
    backing[32'h48 >> 2] = 32'hDEAD_BEEF;
    golden[32'h48 >> 2] = 32'hDEAD_BEEF;
    fixed_lat = 10;
    do_access(1, 0, 32'h40, 0);
    fixed_lat = 0;
    do_access(1, 0, 32'h48, 0);
    check("t1_word2", rdata_o, 32'hDEAD_BEEF);
    // Store hit, then load it back
    do_access(0, 1, 32'h44, 32'h1234_5678);
    do_access(1, 0, 32'h44, 0);
    check("t2_load_stall", stall_o, 0);
    // Dirty conflict miss, then clean conflict miss
    do_access(1, 0, 32'h244, 0);
    do_access(1, 0, 32'h444, 0);
    do_access(1, 0, 32'h444, 0);

    // Reset in the middle of a refill
    hold_ack = 1;
    me_push_refill(32'h640);
    @(posedge clk);
    #1;
    MemRead_i = 1'b1;
    addr_i = 32'h644;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req_o) break;
    end
    check("t5_req_seen", mem_req_o, 1);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(negedge clk);
    check("t5_stall_in_rst", stall_o, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    MemRead_i = 1'b0;
    addr_i = '0;
    @(negedge clk);
    check("t5_req_dropped", mem_req_o, 0);
    check("t5_stall_dropped", stall_o, 0);
    check("t5_addr_cleared", mem_addr_o, 0);
    model_reset();
    hold_ack = 0;
    late_ack = 1;
    for (int i = 0; i < 3; i++) do_access(0, 0, $urandom, $urandom);
    do_access(1, 0, 32'h444, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
      case (kind)
        0:       do_access(0, 0, $urandom, $urandom);
        1, 2:    do_access(1, 0, a, 0);
        3, 4:    do_access(0, 1, a, $urandom);
        default: do_access(1, 1, a, $urandom);
      endcase
    end
    @(posedge clk);
    #1;
    MemRead_i = 1'b0;
    MemWrite_i = 1'b0;
    repeat (2) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("mexp_q_drained", mexp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic me_push_refill(logic [31:0] la);
    mexp_t me;
    me.wr = 0;
    me.addr = la;
    me.wdata = '0;
    mexp_q.push_back(me);
  endtask

endmodule
